// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the ID-stage branch resolution unit: comparator
// forwarding-mux selects and the stall FSM state.
package branch_resolve_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_STALL_LAST = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_fwd_select.sv
// Forwarding select for one branch-comparator operand. EX/MEM wins over
// MEM/WB; a load still in EX/MEM has no data yet, so it never forwards.
module branch_fwd_select
  import branch_resolve_unit_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             ex_mem_regwrite_i,
  input  logic             ex_mem_memread_i,
  input  logic [REG_W-1:0] ex_mem_rd_i,
  input  logic             mem_wb_regwrite_i,
  input  logic [REG_W-1:0] mem_wb_rd_i,
  output logic [1:0]       fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (src_i != '0) begin
      if (ex_mem_regwrite_i && !ex_mem_memread_i && (ex_mem_rd_i == src_i)) begin
        fwd_sel_o = FWD_EXMEM;
      end else if (mem_wb_regwrite_i && (mem_wb_rd_i == src_i)) begin
        fwd_sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: forwarding selects, hazard stall FSM,
// BEQ/BNE decision, target computation and saturating perf counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_branch,
  input  logic              id_bne,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_ex_regwrite,
  input  logic              id_ex_memread,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              ex_mem_regwrite,
  input  logic              ex_mem_memread,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [REG_W-1:0]  mem_wb_rd,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              if_id_flush,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  stall_count
);

  bru_state_e        state_q, state_d;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [REG_W-1:0]  src_regs [2];
  logic [1:0]        sel_raw  [2];
  logic [REG_W-1:0]  src;
  logic              need_one, need_two, hazard;
  logic              stall_raw, resolve, taken;
  logic [DATA_W-1:0] imm_shifted;

  assign src_regs[0] = id_rs;
  assign src_regs[1] = id_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      branch_fwd_select #(.REG_W(REG_W)) u_fwd_select (
        .src_i             (src_regs[gi]),
        .ex_mem_regwrite_i (ex_mem_regwrite),
        .ex_mem_memread_i  (ex_mem_memread),
        .ex_mem_rd_i       (ex_mem_rd),
        .mem_wb_regwrite_i (mem_wb_regwrite),
        .mem_wb_rd_i       (mem_wb_rd),
        .fwd_sel_o         (sel_raw[gi])
      );
    end
  endgenerate

  // Stall requirement is the maximum over both operands and all producers.
  always_comb begin
    need_one = 1'b0;
    need_two = 1'b0;
    src      = '0;
    for (int i = 0; i < 2; i++) begin
      src = src_regs[i];
      if (src != '0) begin
        if (id_ex_memread && (id_ex_rd == src)) need_two = 1'b1;
        if (id_ex_regwrite && !id_ex_memread && (id_ex_rd == src)) need_one = 1'b1;
        if (ex_mem_memread && (ex_mem_rd == src)) need_one = 1'b1;
      end
    end
  end

  assign hazard = id_branch && (need_one || need_two);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      branch_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      branch_count_q <= branch_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_raw = hazard;
        if (id_branch && need_two) state_d = ST_STALL_LAST;
      end
      ST_STALL_LAST: begin
        stall_raw = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall       = stall_raw && !reset;
  assign resolve     = id_branch && !stall_raw && !reset;
  assign taken       = (cmp_a == cmp_b) ^ id_bne;
  assign pc_src      = resolve && taken;
  assign if_id_flush = resolve && taken;

  assign fwd_sel_a = reset ? FWD_RF : sel_raw[0];
  assign fwd_sel_b = reset ? FWD_RF : sel_raw[1];

  assign imm_shifted   = id_imm << 2;
  assign branch_target = id_pc_plus4 + imm_shifted;

  always_comb begin
    branch_count_d = branch_count_q;
    stall_count_d  = stall_count_q;
    if (resolve && (branch_count_q != '1)) branch_count_d = branch_count_q + 1'b1;
    if (stall && (stall_count_q != '1))    stall_count_d  = stall_count_q + 1'b1;
  end

  assign branch_count = branch_count_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expectations are queued per step
// and popped against the DUT outputs sampled shortly after each clock edge.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_branch, id_bne;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] cmp_a, cmp_b, id_pc_plus4, id_imm;
  logic        id_ex_regwrite, id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic        ex_mem_regwrite, ex_mem_memread;
  logic [4:0]  ex_mem_rd;
  logic        mem_wb_regwrite;
  logic [4:0]  mem_wb_rd;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall, pc_src, if_id_flush;
  logic [31:0] branch_target;
  logic [15:0] branch_count, stall_count;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk             (clk),
    .reset           (reset),
    .id_branch       (id_branch),
    .id_bne          (id_bne),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .cmp_a           (cmp_a),
    .cmp_b           (cmp_b),
    .id_pc_plus4     (id_pc_plus4),
    .id_imm          (id_imm),
    .id_ex_regwrite  (id_ex_regwrite),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_memread  (ex_mem_memread),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .fwd_sel_a       (fwd_sel_a),
    .fwd_sel_b       (fwd_sel_b),
    .stall           (stall),
    .pc_src          (pc_src),
    .branch_target   (branch_target),
    .if_id_flush     (if_id_flush),
    .branch_count    (branch_count),
    .stall_count     (stall_count)
  );

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    id_branch = 0; id_bne = 0; id_rs = 0; id_rt = 0;
    cmp_a = 0; cmp_b = 0; id_pc_plus4 = 0; id_imm = 0;
    id_ex_regwrite = 0; id_ex_memread = 0; id_ex_rd = 0;
    ex_mem_regwrite = 0; ex_mem_memread = 0; ex_mem_rd = 0;
    mem_wb_regwrite = 0; mem_wb_rd = 0;
  endtask

  task automatic set_branch(input logic bne, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [31:0] a, input logic [31:0] b);
    id_branch = 1; id_bne = bne; id_rs = rs; id_rt = rt; cmp_a = a; cmp_b = b;
  endtask

  initial begin
    clear_pipe();
    reset = 1;
    // Reset with a hazard-and-forward pattern present: outputs must stay quiet.
    set_branch(1'b0, 5'd1, 5'd1, 32'd3, 32'd3);
    ex_mem_regwrite = 1; ex_mem_rd = 5'd1;
    id_ex_memread = 1; id_ex_rd = 5'd1;
    push_exp("rst_stall", 32'd0);
    push_exp("rst_pc_src", 32'd0);
    push_exp("rst_flush", 32'd0);
    push_exp("rst_fwd_a", 32'(FWD_RF));
    #2;
    check_obs(32'(stall)); check_obs(32'(pc_src));
    check_obs(32'(if_id_flush)); check_obs(32'(fwd_sel_a));
    tick(); tick();
    push_exp("rst_branch_count", 32'd0);
    push_exp("rst_stall_count", 32'd0);
    check_obs(32'(branch_count)); check_obs(32'(stall_count));

    // No hazard, taken BEQ
    reset = 0;
    clear_pipe();
    set_branch(1'b0, 5'd1, 5'd2, 32'd5, 32'd5);
    id_pc_plus4 = 32'h100; id_imm = 32'd4;
    push_exp("nh_stall", 32'd0);
    push_exp("nh_pc_src", 32'd1);
    push_exp("nh_flush", 32'd1);
    push_exp("nh_target", 32'h110);
    push_exp("nh_fwd_b", 32'(FWD_RF));
    #1;
    check_obs(32'(stall)); check_obs(32'(pc_src)); check_obs(32'(if_id_flush));
    check_obs(branch_target); check_obs(32'(fwd_sel_b));
    tick();
    clear_pipe();
    push_exp("nh_branch_count", 32'd1);
    push_exp("idle_pc_src", 32'd0);
    #1;
    check_obs(32'(branch_count)); check_obs(32'(pc_src));

    // ALU producer in ID/EX, BNE on r3
    set_branch(1'b1, 5'd3, 5'd0, 32'd1, 32'd2);
    id_ex_regwrite = 1; id_ex_rd = 5'd3;
    push_exp("alu_c1_stall", 32'd1);
    push_exp("alu_c1_pc_src", 32'd0);
    #1;
    check_obs(32'(stall)); check_obs(32'(pc_src));
    tick();
    id_ex_regwrite = 0; ex_mem_regwrite = 1; ex_mem_rd = 5'd3;
    push_exp("alu_c2_stall", 32'd0);
    push_exp("alu_c2_fwd_a", 32'(FWD_EXMEM));
    push_exp("alu_c2_pc_src", 32'd1);
    push_exp("alu_stall_count", 32'd1);
    #1;
    check_obs(32'(stall)); check_obs(32'(fwd_sel_a)); check_obs(32'(pc_src));
    check_obs(32'(stall_count));
    tick();
    push_exp("alu_branch_count", 32'd2);
    check_obs(32'(branch_count));

    // Load producer in ID/EX, BEQ r4,r4: two stalls then MEM/WB forwarding
    clear_pipe();
    set_branch(1'b0, 5'd4, 5'd4, 32'd7, 32'd7);
    id_ex_regwrite = 1; id_ex_memread = 1; id_ex_rd = 5'd4;
    push_exp("ld_c1_stall", 32'd1);
    #1;
    check_obs(32'(stall));
    tick();
    id_ex_regwrite = 0; id_ex_memread = 0;
    ex_mem_regwrite = 1; ex_mem_memread = 1; ex_mem_rd = 5'd4;
    push_exp("ld_c2_state", 32'(ST_STALL_LAST));
    push_exp("ld_c2_stall", 32'd1);
    push_exp("ld_c2_pc_src", 32'd0);
    #1;
    check_obs(32'(dut.state_q)); check_obs(32'(stall)); check_obs(32'(pc_src));
    tick();
    ex_mem_regwrite = 0; ex_mem_memread = 0;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd4;
    push_exp("ld_c3_stall", 32'd0);
    push_exp("ld_c3_fwd_a", 32'(FWD_MEMWB));
    push_exp("ld_c3_fwd_b", 32'(FWD_MEMWB));
    push_exp("ld_c3_pc_src", 32'd1);
    push_exp("ld_stall_count", 32'd3);
    #1;
    check_obs(32'(stall)); check_obs(32'(fwd_sel_a)); check_obs(32'(fwd_sel_b));
    check_obs(32'(pc_src)); check_obs(32'(stall_count));
    tick();

    // Forwarding priority, load in EX/MEM falls through to MEM/WB
    clear_pipe();
    id_rs = 5'd6; id_rt = 5'd6;
    ex_mem_regwrite = 1; ex_mem_rd = 5'd6;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd6;
    push_exp("prio_fwd_a", 32'(FWD_EXMEM));
    #1;
    check_obs(32'(fwd_sel_a));
    ex_mem_memread = 1;
    push_exp("prio_load_fwd_a", 32'(FWD_MEMWB));
    #1;
    check_obs(32'(fwd_sel_a));

    // Register 0 never forwards or stalls; not-taken BEQ
    clear_pipe();
    set_branch(1'b0, 5'd0, 5'd0, 32'd1, 32'd2);
    id_ex_regwrite = 1; id_ex_memread = 1; id_ex_rd = 5'd0;
    ex_mem_regwrite = 1; ex_mem_rd = 5'd0;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd0;
    push_exp("r0_fwd_a", 32'(FWD_RF));
    push_exp("r0_stall", 32'd0);
    push_exp("r0_pc_src", 32'd0);
    #1;
    check_obs(32'(fwd_sel_a)); check_obs(32'(stall)); check_obs(32'(pc_src));
    tick();
    push_exp("r0_branch_count", 32'd4);
    check_obs(32'(branch_count));

    // Target arithmetic wraps and drops the immediate's top bits
    clear_pipe();
    id_pc_plus4 = 32'hFFFF_FFFC; id_imm = 32'hFFFF_FFFF;
    push_exp("tgt_wrap", 32'hFFFF_FFF8);
    #1;
    check_obs(branch_target);
    id_pc_plus4 = 32'h0000_1000; id_imm = 32'hC000_0001;
    push_exp("tgt_topbits", 32'h0000_1004);
    #1;
    check_obs(branch_target);

    // Reset asserted in STALL_LAST aborts the stall
    clear_pipe();
    set_branch(1'b0, 5'd8, 5'd9, 32'd0, 32'd0);
    id_ex_regwrite = 1; id_ex_memread = 1; id_ex_rd = 5'd9;
    tick();
    push_exp("rms_state", 32'(ST_STALL_LAST));
    check_obs(32'(dut.state_q));
    reset = 1;
    push_exp("rms_rst_stall", 32'd0);
    #1;
    check_obs(32'(stall));
    tick();
    reset = 0;
    clear_pipe();
    push_exp("rms_stall", 32'd0);
    push_exp("rms_state_idle", 32'(ST_IDLE));
    push_exp("rms_branch_count", 32'd0);
    push_exp("rms_stall_count", 32'd0);
    #1;
    check_obs(32'(stall)); check_obs(32'(dut.state_q));
    check_obs(32'(branch_count)); check_obs(32'(stall_count));

    // Branch counter saturation from a preloaded value
    force dut.branch_count_q = 16'hFFFE;
    #1;
    release dut.branch_count_q;
    set_branch(1'b0, 5'd1, 5'd2, 32'd0, 32'd0);
    tick();
    push_exp("sat_reach_max", 32'h0000_FFFF);
    check_obs(32'(branch_count));
    tick();
    push_exp("sat_hold_max", 32'h0000_FFFF);
    check_obs(32'(branch_count));

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch resolution and hazard control for the 5-stage pipeline with early (ID-stage) branches. Produces the 2-bit select for each of the two comparator forwarding muxes, consumes their outputs to decide BEQ/BNE, computes the branch target, and drives the PC source and IF/ID flush. A small stall FSM holds IF/ID and the PC when an operand is not yet forwardable. Two saturating performance counters record resolved branches and stall cycles.

## Interface
- DATA_W, 32, operand/PC width
- REG_W, 5, register index width
- CNT_W, 16, performance counter width
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- id_branch  in  1  instruction in ID is BEQ/BNE
- id_bne  in  1  1 = BNE, 0 = BEQ
- id_rs, id_rt  in  REG_W  source registers of the ID instruction
- cmp_a, cmp_b  in  DATA_W  forwarding-mux outputs for rs/rt
- id_pc_plus4  in  DATA_W  PC+4 of the ID instruction
- id_imm  in  DATA_W  sign-extended immediate
- id_ex_regwrite, id_ex_memread  in  1  ID/EX control
- id_ex_rd  in  REG_W  ID/EX destination
- ex_mem_regwrite, ex_mem_memread  in  1  EX/MEM control
- ex_mem_rd  in  REG_W  EX/MEM destination
- mem_wb_regwrite  in  1  MEM/WB control
- mem_wb_rd  in  REG_W  MEM/WB destination
- fwd_sel_a, fwd_sel_b  out  2  mux selects: 00 register file, 01 MEM/WB, 10 EX/MEM (11 never driven)
- stall  out  1  hold PC and IF/ID, bubble ID/EX
- pc_src  out  1  branch taken; select branch_target
- branch_target  out  DATA_W  id_pc_plus4 + (id_imm << 2)
- if_id_flush  out  1  squash fetched instruction
- branch_count, stall_count  out  CNT_W  saturating performance counters

## Operation
- Forward select per operand (rs shown; rt identical): 10 if ex_mem_regwrite & !ex_mem_memread & ex_mem_rd==rs & rs!=0; else 01 if mem_wb_regwrite & mem_wb_rd==rs & rs!=0; else 00. EX/MEM has priority over MEM/WB.
- Hazard detection applies only when id_branch=1. The operand set is rs and rt, excluding register 0.
  - ALU producer in ID/EX (id_ex_regwrite & !id_ex_memread, rd matches): need 1 stall.
  - Load in ID/EX (id_ex_memread, rd matches): need 2 stalls.
  - Load in EX/MEM (ex_mem_memread, rd matches): need 1 stall.
  - If several apply, take the maximum.
- FSM states:
  - IDLE: stall = hazard. With need 2, go to STALL_LAST. With need 1, stay in IDLE; the hazard has cleared by the next cycle because the producer has advanced.
  - STALL_LAST: stall = 1 unconditionally, then return to IDLE.
- Resolution happens only when id_branch=1 and stall=0:
  - taken = (cmp_a==cmp_b) XOR id_bne.
  - pc_src = if_id_flush = taken.
- pc_src and if_id_flush are 0 whenever stall=1 or id_branch=0.
- branch_target is always driven. Arithmetic is modulo 2^DATA_W; the immediate shift discards its top 2 bits.
- branch_count increments on each resolution, taken or not. stall_count increments on each cycle with stall=1. Both saturate at all-ones.

## Timing
- fwd_sel_*, stall, pc_src, if_id_flush and branch_target are combinational from the current inputs and the FSM state, so they are valid in the same cycle. The PC and IF/ID act on them at the next rising edge.
- Branch penalty:
  - Taken branch: 1 flushed slot.
  - No hazard: 0 stalls.
  - Dependency on a load immediately before the branch: exactly 2 stall cycles, then resolution with fwd_sel=01.
- Reset: on the edge with reset=1, state becomes IDLE and both counters become 0. While reset=1, stall, pc_src and if_id_flush are 0 and fwd_sel_* are 00.
- Reset asserted in STALL_LAST aborts the stall: the next cycle is IDLE with stall=0.
- id_branch dropping in STALL_LAST is a protocol violation. The unit still returns to IDLE.

## Structure
- Shared package: the FWD_RF/FWD_MEMWB/FWD_EXMEM select encodings (consumed by the comparator forwarding mux) and the FSM state encoding.
- One natural sub-module: branch_fwd_select. It computes the select for one operand and is instantiated twice.

## Test plan
- No hazard: BEQ, rs=1 and rt=2 with cmp_a=cmp_b=5, id_pc_plus4=0x100, id_imm=4 -> stall=0, pc_src=1, if_id_flush=1, branch_target=0x110, branch_count=1.
- ALU producer: `add r3` in ID/EX, BNE on r3 -> cycle 1: stall=1. Cycle 2: fwd_sel_a=10, resolves, stall_count=1.
- Load producer: `lw r4` in ID/EX, BEQ on r4,r4 -> 2 stall cycles (state STALL_LAST in the 2nd), then fwd_sel_a=fwd_sel_b=01, pc_src=1, stall_count=2.
- Priority and register 0:
  - ex_mem_rd = mem_wb_rd = 6, both writing, rs=6 -> fwd_sel_a=10.
  - rs=0 with every stage writing r0 -> fwd_sel_a=00 and no stall.
- Reset mid-stall: assert reset during STALL_LAST -> next cycle stall=0 and both counters 0.
- Counter saturation: preload branch_count to 0xFFFF via forced state, then resolve one branch -> branch_count stays 0xFFFF.
